// File: rtl/instr_issue_ctrl.sv
// Issue sequencer: buffers instructions, feeds the decoder one at a time, retires on execute completion.
// Optional EXEC watchdog enabled by defining ISSUE_TIMEOUT_EN.
module instr_issue_ctrl #(
    parameter int BUS_WIDTH      = 33,
    parameter int OPCODE_WIDTH   = 5,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [BUS_WIDTH-1:0]               in_instr,
    output logic                               in_ready,
    input  logic                               flush,
    output logic                               instr_valid,
    output logic [BUS_WIDTH-1:0]               instr,
    input  logic [OPCODE_WIDTH-1:0]            dec_opcode,
    input  logic                               exe_done,
    input  logic [OPCODE_WIDTH-1:0]            exe_done_op,
    output logic [OPCODE_WIDTH-1:0]            op_done,
    output logic                               next_instr,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               err_mismatch,
    output logic                               err_timeout
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;

    logic [BUS_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [2:0]              state_q, state_d;
    logic [BUS_WIDTH-1:0]    instr_q, instr_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    err_mis_q, err_mis_d;
    logic                    full, empty, push, pop, match, expire;

    assign full  = (count_q == FULL);
    assign empty = (count_q == '0);
    assign push  = in_valid & ~full & ~flush;
    assign match = exe_done & (exe_done_op == op_q);

`ifdef ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_tmo_q, err_tmo_d;

    // Counter is zero on the first EXEC cycle because it idles at zero elsewhere.
    assign expire = (state_q == S_EXEC) & (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d     = (state_q == S_EXEC) ? tmo_q + TW'(1) : '0;
        err_tmo_d = err_tmo_q | (expire & ~match);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_timeout = err_tmo_q;
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_d      = op_q;
        err_mis_d = err_mis_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_DECODE;
            S_DECODE: begin
                op_d    = dec_opcode;
                state_d = (dec_opcode == '0) ? S_RETIRE : S_EXEC;
            end
            S_EXEC: begin
                if (match || expire) state_d = S_RETIRE;
                if (exe_done && !match) err_mis_d = 1'b1;
            end
            S_RETIRE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
        end
        if (pop) instr_d = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            instr_q   <= '0;
            op_q      <= '0;
            err_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            op_q      <= op_d;
            err_mis_q <= err_mis_d;
        end
    end

    assign in_ready     = rst_n & ~full;
    assign instr_valid  = (state_q == S_ISSUE);
    assign instr        = instr_q;
    assign next_instr   = (state_q == S_RETIRE);
    assign op_done      = next_instr ? op_q : '0;
    assign busy         = (state_q != S_IDLE);
    assign fifo_count   = count_q;
    assign err_mismatch = err_mis_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: directed scenarios plus random traffic against a queue-based model.
// Timeout scenario runs when ISSUE_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_instr_issue_ctrl;

    localparam int BW  = 33;
    localparam int OW  = 5;
    localparam int D   = 4;
    localparam int TMO = 8;
    localparam int CWT = $clog2(D + 1);
`ifdef ISSUE_TIMEOUT_EN
    localparam int MIS_WAIT = 4;
`else
    localparam int MIS_WAIT = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_instr = '0;
    logic          flush = 1'b0;
    logic [OW-1:0] dec_opcode = '0;
    logic          exe_done = 1'b0;
    logic [OW-1:0] exe_done_op = '0;
    logic          in_ready, instr_valid, next_instr, busy;
    logic          err_mismatch, err_timeout;
    logic [BW-1:0] instr;
    logic [OW-1:0] op_done;
    logic [CWT-1:0] fifo_count;

    instr_issue_ctrl #(
        .BUS_WIDTH(BW), .OPCODE_WIDTH(OW),
        .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush),
        .instr_valid(instr_valid), .instr(instr),
        .dec_opcode(dec_opcode),
        .exe_done(exe_done), .exe_done_op(exe_done_op),
        .op_done(op_done), .next_instr(next_instr), .busy(busy),
        .fifo_count(fifo_count),
        .err_mismatch(err_mismatch), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int obs_ret = 0;

    // Model: instructions waiting to issue, plus the one op in flight.
    logic [BW-1:0] q[$];
    bit            infl = 0;
    int            age = 0;
    logic [OW-1:0] cur_op = '0;
    bit            exp_err = 0;
    bit            exp_tmo = 0;
    int            exe_mode = 0;
    int            dec_mode = 0;
    bit            rand_in = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc, fl, exc, m, w, nopr, tf, iv, expni;
        logic [BW-1:0] d;
        int r;
        acc  = in_valid && (q.size() != D) && !flush;
        d    = in_instr;
        fl   = flush;
        exc  = infl && age >= 2 && cur_op != 0;
        m    = exc && exe_done && (exe_done_op == cur_op);
        w    = exc && exe_done && (exe_done_op != cur_op);
        nopr = infl && age == 1 && cur_op == 0;
        tf   = 0;
`ifdef ISSUE_TIMEOUT_EN
        tf   = exc && !m && (age == TMO + 1);
`endif
        iv   = !infl && q.size() > 0 && !fl;
        @(posedge clk);
        #1;
        cyc++;
        if (w) exp_err = 1;
        if (tf) exp_tmo = 1;
        expni = (m || nopr || tf) && !fl;
        if (fl) begin
            q.delete();
            infl = 0;
        end else if (acc) begin
            q.push_back(d);
        end
        if (infl) age++;
        if (next_instr === 1'b1) obs_ret++;
        chk("next_instr", next_instr, expni);
        chk("op_done", op_done, expni ? cur_op : '0);
        if (expni) infl = 0;
        chk("instr_valid", instr_valid, iv);
        if (iv) begin
            chk("issue_order", instr, q[0]);
            void'(q.pop_front());
            infl = 1;
            age  = 0;
            if (dec_mode < 0)
                cur_op = ($urandom_range(0, 2) == 0) ? '0 : OW'($urandom_range(1, 31));
            else
                cur_op = OW'(dec_mode);
        end
        chk("busy", busy, infl || expni);
        chk("fifo_count", fifo_count, q.size());
        chk("in_ready", in_ready, q.size() != D);
        chk("err_mismatch", err_mismatch, exp_err);
        chk("err_timeout", err_timeout, exp_tmo);
        in_valid    = 0;
        flush       = 0;
        exe_done    = 0;
        exe_done_op = OW'($urandom);
        dec_opcode  = (infl && age == 1) ? cur_op : OW'($urandom);
        if (rand_in) begin
            in_valid = 1'($urandom);
            in_instr = {1'($urandom), $urandom};
        end
        exc = infl && age >= 2 && cur_op != 0;
        r = $urandom_range(0, 7);
        if (exc && exe_mode == 2) begin
            exe_done    = 1;
            exe_done_op = cur_op;
        end else if (exc && exe_mode == 1) begin
            if (r < 2) begin
                exe_done    = 1;
                exe_done_op = cur_op;
            end else if (r == 2) begin
                exe_done    = 1;
                exe_done_op = cur_op ^ OW'($urandom_range(1, 31));
            end
        end else if (!exc && exe_mode == 1 && r == 0) begin
            exe_done = 1;
        end
    endtask

    task automatic push_and_tick(input logic [BW-1:0] v);
        in_valid = 1;
        in_instr = v;
        tick();
    endtask

    int base;
    int e_cyc;

    initial begin
        // Reset values while rst_n is held low.
        #2;
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_next_instr", next_instr, 0);
        chk("rst_op_done", op_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_instr", instr, 0);
        chk("rst_err_mismatch", err_mismatch, 0);
        chk("rst_err_timeout", err_timeout, 0);
        #10;
        rst_n = 1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_busy", busy, 0);

        // NOP: issue at N+2, retire at N+4 with op_done=0.
        dec_mode = 0;
        exe_mode = 0;
        push_and_tick(33'h0_0000_0013);
        tick();
        chk("nop_iv_n2", instr_valid, 1);
        chk("nop_instr", instr, 33'h13);
        tick();
        tick();
        chk("nop_ni_n4", next_instr, 1);
        chk("nop_op_done", op_done, 0);
        tick();

        // Wrong-opcode completion, then the right one.
        dec_mode = 5;
        push_and_tick(33'h1_2345_6789);
        repeat (3) tick();
        exe_done    = 1;
        exe_done_op = 3;
        tick();
        chk("mis_flag", err_mismatch, 1);
        chk("mis_no_retire", next_instr, 0);
        repeat (MIS_WAIT - 1) tick();
        exe_done    = 1;
        exe_done_op = 5;
        base = obs_ret;
        tick();
        chk("mis_retire", next_instr, 1);
        chk("mis_retire_op", op_done, 5);
        tick();
        chk("mis_single_retire", obs_ret - base, 1);

        // Fill with execute stalled, then drain in order across pointer wrap.
        dec_mode = 7;
        for (int i = 0; i < 5; i++)
            push_and_tick(33'h1_0000_0000 | BW'(i * 32'h111));
        chk("fill_count", fifo_count, 4);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_busy", busy, 1);
        push_and_tick(33'h0_dead_beef);
        chk("full_reject", fifo_count, 4);
        base = obs_ret;
        exe_mode = 2;
        repeat (40) tick();
        chk("fill_retires", obs_ret - base, 5);
        chk("fill_empty", fifo_count, 0);

        // Flush mid-EXEC with three queued; a same-cycle push is dropped.
        exe_mode = 0;
        dec_mode = 9;
        for (int i = 0; i < 4; i++)
            push_and_tick(33'h0_0f0f_0000 | BW'(i));
        chk("pre_flush_count", fifo_count, 3);
        flush    = 1;
        in_valid = 1;
        in_instr = 33'h1_ffff_ffff;
        base = obs_ret;
        tick();
        chk("flush_count", fifo_count, 0);
        chk("flush_busy", busy, 0);
        tick();
        tick();
        chk("flush_no_retire", obs_ret - base, 0);
        chk("flush_keeps_err", err_mismatch, 1);

        // Asynchronous reset in the middle of EXEC.
        dec_mode = 6;
        push_and_tick(33'h0_0000_0abc);
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_next_instr", next_instr, 0);
        chk("arst_instr_valid", instr_valid, 0);
        chk("arst_fifo_count", fifo_count, 0);
        chk("arst_instr", instr, 0);
        chk("arst_err_mismatch", err_mismatch, 0);
        q.delete();
        infl    = 0;
        exp_err = 0;
        exp_tmo = 0;
        #2;
        rst_n = 1;
        tick();

`ifdef ISSUE_TIMEOUT_EN
        // Watchdog forces retire TIMEOUT_CYCLES after EXEC entry.
        dec_mode = 4;
        push_and_tick(33'h0_0000_0777);
        repeat (3) tick();
        e_cyc = cyc;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (next_instr === 1'b1) break;
        end
        chk("tmo_latency", cyc - e_cyc, TMO);
        chk("tmo_op_done", op_done, 4);
        tick();
        chk("tmo_flag", err_timeout, 1);
`endif

        // Random traffic against the model.
        dec_mode = -1;
        exe_mode = 1;
        rand_in  = 1;
        repeat (800) tick();
        rand_in  = 0;
        exe_mode = 2;
        repeat (60) tick();
        chk("drain_busy", busy, 0);
        chk("drain_count", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
